// File: rtl/rr_arbiter_lock_if.sv
// Request/grant bundle between N requesters and rr_arbiter_lock.
// master = requester side, slave = arbiter side.
interface rr_arbiter_lock_if #(
    parameter int N = 8
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  last;
    logic [N-1:0]  grant;
    logic          grant_vld;
    logic [IW-1:0] grant_idx;

    modport master (
        output req,
        output last,
        input  grant,
        input  grant_vld,
        input  grant_idx
    );

    modport slave (
        input  req,
        input  last,
        output grant,
        output grant_vld,
        output grant_idx
    );
endinterface

// File: rtl/rr_arbiter_lock.sv
// Round-robin arbiter holding each grant until last, request drop or burst limit.
// Optional burst limit compiled in with `define RR_ARB_BURST_LIMIT_EN.
module rr_arbiter_lock #(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input logic              clk,
    input logic              rstn,
    rr_arbiter_lock_if.slave bus
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state, state_nx;
    logic [N-1:0]  grant, grant_nx;
    logic          grant_vld;
    logic [IW-1:0] grant_idx, idx_nx;
    logic [IW-1:0] ptr, ptr_nx, ptr_inc, srch_ptr;
    logic [IW:0]   srch;
    logic          owner_rel;
    logic          burst_done;

`ifdef RR_ARB_BURST_LIMIT_EN
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [CW-1:0] cnt, cnt_nx;

    assign burst_done = (cnt == CW'(MAX_BURST));
`else
    // MAX_BURST only matters when the burst limit is built in.
    logic unused_max_burst;

    assign unused_max_burst = (MAX_BURST > 0);
    assign burst_done       = 1'b0;
`endif

    // Returns {found, index} of the first request at or after p, wrapping mod N.
    function automatic logic [IW:0] rr_search(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic          found;
        logic [IW-1:0] idx;
        logic [IW-1:0] pos;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            pos = IW'((int'(p) + i) % N);
            if (!found && r[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        return {found, idx};
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // On release the old owner becomes lowest priority, so the search starts just past it.
    assign ptr_inc   = (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
    assign srch_ptr  = (state == OWN) ? ptr_inc : ptr;
    assign srch      = rr_search(bus.req, srch_ptr);
    assign owner_rel = !bus.req[grant_idx] || bus.last[grant_idx] || burst_done;

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        idx_nx   = grant_idx;
        ptr_nx   = ptr;
`ifdef RR_ARB_BURST_LIMIT_EN
        cnt_nx   = cnt;
`endif
        unique case (state)
            IDLE: begin
                if (srch[IW]) begin
                    state_nx = OWN;
                    grant_nx = onehot(srch[IW-1:0]);
                    idx_nx   = srch[IW-1:0];
`ifdef RR_ARB_BURST_LIMIT_EN
                    cnt_nx   = CW'(1);
`endif
                end
            end
            OWN: begin
                if (owner_rel) begin
                    ptr_nx = ptr_inc;
                    if (srch[IW]) begin
                        grant_nx = onehot(srch[IW-1:0]);
                        idx_nx   = srch[IW-1:0];
`ifdef RR_ARB_BURST_LIMIT_EN
                        cnt_nx   = CW'(1);
`endif
                    end else begin
                        state_nx = IDLE;
                        grant_nx = '0;
                        idx_nx   = '0;
`ifdef RR_ARB_BURST_LIMIT_EN
                        cnt_nx   = '0;
`endif
                    end
                end else begin
`ifdef RR_ARB_BURST_LIMIT_EN
                    if (cnt != CW'(MAX_BURST)) cnt_nx = cnt + CW'(1);
`endif
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            grant     <= '0;
            grant_vld <= 1'b0;
            grant_idx <= '0;
            ptr       <= '0;
`ifdef RR_ARB_BURST_LIMIT_EN
            cnt       <= '0;
`endif
        end else begin
            state     <= state_nx;
            grant     <= grant_nx;
            grant_vld <= |grant_nx;
            grant_idx <= idx_nx;
            ptr       <= ptr_nx;
`ifdef RR_ARB_BURST_LIMIT_EN
            cnt       <= cnt_nx;
`endif
        end
    end

    assign bus.grant     = grant;
    assign bus.grant_vld = grant_vld;
    assign bus.grant_idx = grant_idx;

endmodule
